// File: rtl/store_unit_pkg.sv
// Shared store-size encodings, device-buffer state encoding and lane-generator result type
// for the M-stage store unit.
package store_unit_pkg;

    localparam logic [1:0] STORE_NONE = 2'b00;
    localparam logic [1:0] STORE_HALF = 2'b01;
    localparam logic [1:0] STORE_BYTE = 2'b10;
    localparam logic [1:0] STORE_WORD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dev_state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        misaligned;
    } lane_t;

    // The device only sees word addresses; the byte lanes travel in the enables.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Turns a store size, the low address bits and the rt value into byte enables,
// lane-replicated write data and a misalignment flag. Purely combinational.
module store_lane_gen
    import store_unit_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    output lane_t       lane
);

    // A misaligned access keeps its data but never enables any lane.
    always_comb begin
        lane = '0;
        case (sel)
            STORE_WORD: begin
                lane.wdata = wd;
                if (addr_lo != 2'b00) begin
                    lane.misaligned = 1'b1;
                end else begin
                    lane.be = 4'b1111;
                end
            end
            STORE_HALF: begin
                lane.wdata = {2{wd[15:0]}};
                if (addr_lo[0]) begin
                    lane.misaligned = 1'b1;
                end else begin
                    lane.be = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
            end
            STORE_BYTE: begin
                lane.wdata = {4{wd[7:0]}};
                lane.be    = 4'b0001 << addr_lo;
            end
            default: begin
                lane = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// M-stage store unit: drives data-memory byte lanes directly and posts device writes
// through a one-entry buffer with a req/ack handshake, stalling M only on overtaking.
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit STALL_ON_DEVLOAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  storeselM,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] WD_M,
    input  logic        HitDMM,
    input  logic        devloadM,
    output logic [3:0]  DM_WE,
    output logic [31:0] DM_WD,
    output logic        AdES_M,
    output logic        dev_req,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic [3:0]  dev_be,
    input  logic        dev_ack,
    output logic        stall_M
);

    lane_t      lane;
    logic       store_valid;
    logic       new_dev_store;
    logic       capture;
    dev_state_t state;
    dev_state_t next_state;

    store_lane_gen u_lane_gen (
        .sel     (storeselM),
        .addr_lo (ALUout_M[1:0]),
        .wd      (WD_M),
        .lane    (lane)
    );

    assign store_valid   = (storeselM != STORE_NONE) && !lane.misaligned;
    assign new_dev_store = store_valid && !HitDMM;
    assign AdES_M        = lane.misaligned;
    assign DM_WD         = lane.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An ack releases the entry and frees the slot for a store arriving in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (new_dev_store) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dev_ack && !new_dev_store) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_M = 1'b0;
        capture = 1'b0;
        DM_WE   = 4'b0000;
        case (state)
            ST_IDLE: begin
                capture = new_dev_store;
            end
            ST_BUSY: begin
                stall_M = !dev_ack &&
                          (new_dev_store || (devloadM && STALL_ON_DEVLOAD));
                capture = new_dev_store && dev_ack;
            end
            default: begin
                capture = 1'b0;
            end
        endcase
        if (store_valid && HitDMM && !stall_M) begin
            DM_WE = lane.be;
        end
    end

    // The posted-write registers only change on capture; they hold steady while BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            dev_req   <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            dev_be    <= 4'b0000;
        end else begin
            dev_req <= (next_state == ST_BUSY);
            if (capture) begin
                dev_addr  <= word_addr(ALUout_M);
                dev_wdata <= lane.wdata;
                dev_be    <= lane.be;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_store_unit;

    localparam bit STALL_DL = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  storeselM = 2'b00;
    logic [31:0] ALUout_M = '0;
    logic [31:0] WD_M = '0;
    logic        HitDMM = 1'b0;
    logic        devloadM = 1'b0;
    logic        dev_ack = 1'b0;
    logic [3:0]  DM_WE;
    logic [31:0] DM_WD;
    logic        AdES_M;
    logic        dev_req;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_be;
    logic        stall_M;

    int total = 0;
    int bad = 0;
    bit model_on = 1'b0;

    // Model state: the single pending posted write, if any.
    bit          m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_be = '0;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] data;
        bit          mis;
    } exp_t;

    store_unit #(.STALL_ON_DEVLOAD(STALL_DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .storeselM (storeselM),
        .ALUout_M  (ALUout_M),
        .WD_M      (WD_M),
        .HitDMM    (HitDMM),
        .devloadM  (devloadM),
        .DM_WE     (DM_WE),
        .DM_WD     (DM_WD),
        .AdES_M    (AdES_M),
        .dev_req   (dev_req),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_be    (dev_be),
        .dev_ack   (dev_ack),
        .stall_M   (stall_M)
    );

    always #5 clk = ~clk;

    function automatic exp_t expect_lane(input logic [1:0] sel, input logic [31:0] addr,
                                         input logic [31:0] wd);
        exp_t e;
        int   a;
        a = int'(addr[1:0]);
        e.be = 4'b0000;
        e.data = '0;
        e.mis = 1'b0;
        if (sel == 2'b11) begin
            e.data = wd;
            e.mis = (a != 0);
            if (!e.mis) e.be = 4'b1111;
        end else if (sel == 2'b01) begin
            e.data = 32'(wd[15:0]) * 32'h0001_0001;
            e.mis = (a % 2) != 0;
            if (!e.mis) e.be = (a >= 2) ? 4'b1100 : 4'b0011;
        end else if (sel == 2'b10) begin
            e.data = 32'(wd[7:0]) * 32'h0101_0101;
            e.be = 4'(2 ** a);
        end
        return e;
    endfunction

    function automatic bit is_dev_store();
        exp_t e;
        e = expect_lane(storeselM, ALUout_M, WD_M);
        return (storeselM != 2'b00) && !e.mis && !HitDMM;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] sel, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic hit, input logic dl,
                                 input logic ack);
        @(posedge clk);
        #1;
        reset = rst;
        storeselM = sel;
        ALUout_M = addr;
        WD_M = wd;
        HitDMM = hit;
        devloadM = dl;
        dev_ack = ack;
        #2;
    endtask

    // Behavioural model of the posted-write buffer, advanced on each clock edge.
    always @(posedge clk) begin
        if (reset) begin
            m_pend <= 1'b0;
        end else if (is_dev_store() && (!m_pend || dev_ack)) begin
            m_pend <= 1'b1;
            m_addr <= ALUout_M & 32'hFFFF_FFFC;
            m_data <= expect_lane(storeselM, ALUout_M, WD_M).data;
            m_be   <= expect_lane(storeselM, ALUout_M, WD_M).be;
        end else if (m_pend && dev_ack) begin
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            exp_t e;
            bit   st;
            e = expect_lane(storeselM, ALUout_M, WD_M);
            st = m_pend && !dev_ack && (is_dev_store() || (devloadM && STALL_DL));
            checkOutput("m_stall", 32'(stall_M), 32'(st));
            checkOutput("m_ades", 32'(AdES_M), 32'(e.mis));
            checkOutput("m_dm_wd", DM_WD, e.data);
            checkOutput("m_dm_we", 32'(DM_WE),
                        (storeselM != 2'b00 && HitDMM && !e.mis && !st) ? 32'(e.be) : 32'd0);
            checkOutput("m_dev_req", 32'(dev_req), 32'(m_pend));
            if (m_pend) begin
                checkOutput("m_dev_addr", dev_addr, m_addr);
                checkOutput("m_dev_wdata", dev_wdata, m_data);
                checkOutput("m_dev_be", 32'(dev_be), 32'(m_be));
            end
        end
    end

    initial begin
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_req", 32'(dev_req), 32'd0);
        checkOutput("rst_addr", dev_addr, 32'd0);
        checkOutput("rst_wdata", dev_wdata, 32'd0);
        checkOutput("rst_be", 32'(dev_be), 32'd0);
        checkOutput("rst_dm_we", 32'(DM_WE), 32'd0);
        checkOutput("rst_dm_wd", DM_WD, 32'd0);
        checkOutput("rst_stall", 32'(stall_M), 32'd0);
        model_on = 1'b1;

        applyStimulus(1'b0, 2'b10, 32'h0000_1002, 32'h1234_56AB, 1'b1, 1'b0, 1'b0);
        checkOutput("sb_we", 32'(DM_WE), 32'h4);
        checkOutput("sb_wd", DM_WD, 32'hABAB_ABAB);
        checkOutput("sb_ades", 32'(AdES_M), 32'd0);

        applyStimulus(1'b0, 2'b01, 32'h0000_2002, 32'hFFFF_BEEF, 1'b1, 1'b0, 1'b0);
        checkOutput("sh_we", 32'(DM_WE), 32'hC);
        checkOutput("sh_wd", DM_WD, 32'hBEEF_BEEF);

        applyStimulus(1'b0, 2'b01, 32'h7F00_0001, 32'h0000_1111, 1'b0, 1'b0, 1'b0);
        checkOutput("sh_mis_ades", 32'(AdES_M), 32'd1);
        checkOutput("sh_mis_we", 32'(DM_WE), 32'd0);

        applyStimulus(1'b0, 2'b11, 32'h7F00_0003, 32'h2222_3333, 1'b0, 1'b0, 1'b0);
        checkOutput("sw_mis_ades", 32'(AdES_M), 32'd1);
        checkOutput("sw_mis_we", 32'(DM_WE), 32'd0);
        checkOutput("sh_mis_nocap", 32'(dev_req), 32'd0);

        applyStimulus(1'b0, 2'b11, 32'h7F00_0004, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        checkOutput("sw_mis_nocap", 32'(dev_req), 32'd0);
        checkOutput("dev_sw_nostall", 32'(stall_M), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("dev_req_hold", 32'(dev_req), 32'd1);
            checkOutput("dev_addr_hold", dev_addr, 32'h7F00_0004);
            checkOutput("dev_wdata_hold", dev_wdata, 32'hCAFE_F00D);
            checkOutput("dev_be_hold", 32'(dev_be), 32'hF);
        end
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("ack_cycle_req", 32'(dev_req), 32'd1);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("after_ack_req", 32'(dev_req), 32'd0);

        applyStimulus(1'b0, 2'b11, 32'h7F00_0010, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 32'h7F00_0020, 32'h0000_005A, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_stall1", 32'(stall_M), 32'd1);
        applyStimulus(1'b0, 2'b10, 32'h7F00_0020, 32'h0000_005A, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_stall2", 32'(stall_M), 32'd1);
        checkOutput("b2b_old_addr", dev_addr, 32'h7F00_0010);
        applyStimulus(1'b0, 2'b10, 32'h7F00_0020, 32'h0000_005A, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b_ack_nostall", 32'(stall_M), 32'd0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_req", 32'(dev_req), 32'd1);
        checkOutput("b2b_addr", dev_addr, 32'h7F00_0020);
        checkOutput("b2b_be", 32'(dev_be), 32'h1);
        checkOutput("b2b_wdata", dev_wdata, 32'h5A5A_5A5A);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("devload_stall", 32'(stall_M), 32'd1);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("devload_ack", 32'(stall_M), 32'd0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_req", 32'(dev_req), 32'd0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_ack_ignored", 32'(dev_req), 32'd0);

        applyStimulus(1'b0, 2'b11, 32'h7F00_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_mid_busy", 32'(dev_req), 32'd1);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_mid_req", 32'(dev_req), 32'd0);
        checkOutput("rst_mid_be", 32'(dev_be), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] sel;
            logic       dl;
            sel = 2'($urandom_range(0, 3));
            dl  = (sel == 2'b00) && ($urandom_range(0, 3) == 0);
            applyStimulus(($urandom_range(0, 63) == 0), sel,
                          ($urandom_range(0, 1) == 1) ? (32'h7F00_0000 | 32'($urandom_range(0, 255)))
                                                      : 32'($urandom),
                          32'($urandom), 1'($urandom_range(0, 1)), dl,
                          1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        model_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
